// File: rtl/copy_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : copy_sched_pkg
// Brief   : Shared types for the copy scheduler: state encoding, job record,
//           default field widths and timeout.
// Revision: 1.0
// ============================================================================
package copy_sched_pkg;

    localparam int c_ADDR_W          = 8;
    localparam int c_TAG_W           = 2;
    localparam int c_TIMEOUT_DEFAULT = 1024;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LAUNCH = 3'd1;
    localparam logic [2:0] c_S_WAIT   = 3'd2;
    localparam logic [2:0] c_S_RETIRE = 3'd3;
    localparam logic [2:0] c_S_FAULT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = c_S_IDLE,
        LAUNCH = c_S_LAUNCH,
        WAIT   = c_S_WAIT,
        RETIRE = c_S_RETIRE,
        FAULT  = c_S_FAULT
    } sched_state_t;

    typedef struct packed {
        logic [c_ADDR_W-1:0] src;
        logic [c_ADDR_W-1:0] dst;
        logic [c_ADDR_W-1:0] size;
        logic [c_TAG_W-1:0]  tag;
    } job_t;

endpackage
`default_nettype wire

// File: rtl/copy_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : copy_sched_if
// Brief   : Requester, copier and completion signals of the copy scheduler.
//           master = requester/copier side, slave = scheduler side.
// Revision: 1.0
// ============================================================================
interface copy_sched_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int TAG_W  = 2
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_W-1:0]      req_src;
    logic [ADDR_W-1:0]      req_dst;
    logic [ADDR_W-1:0]      req_size;
    logic [TAG_W-1:0]       req_tag;
    logic                   cp_start;
    logic [ADDR_W-1:0]      cp_src;
    logic [ADDR_W-1:0]      cp_dst;
    logic [ADDR_W-1:0]      cp_size;
    logic                   cp_finished;
    logic                   done_valid;
    logic [TAG_W-1:0]       done_tag;
    logic                   done_err;
    logic                   busy;
    logic [$clog2(DEPTH):0] queue_count;

    modport master (
        output req_valid, req_src, req_dst, req_size, req_tag, cp_finished,
        input  req_ready, cp_start, cp_src, cp_dst, cp_size,
        input  done_valid, done_tag, done_err, busy, queue_count
    );

    modport slave (
        input  req_valid, req_src, req_dst, req_size, req_tag, cp_finished,
        output req_ready, cp_start, cp_src, cp_dst, cp_size,
        output done_valid, done_tag, done_err, busy, queue_count
    );
endinterface
`default_nettype wire

// File: rtl/copy_job_fifo.sv
`default_nettype none
// ============================================================================
// Module  : copy_job_fifo
// Brief   : Synchronous descriptor FIFO of job_t; pointers carry an extra
//           wrap bit so full and empty are distinguishable.
// Revision: 1.0
// ============================================================================
module copy_job_fifo
    import copy_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   CLK,
    input  wire logic                   RST,
    input  wire logic                   i_push,
    input  wire logic                   i_pop,
    input  wire job_t                   i_wr_data,
    output job_t                        o_rd_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);
    localparam int c_PTR_W = $clog2(DEPTH);

    job_t               r_mem [DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty   = (o_count == '0);

endmodule
`default_nettype wire

// File: rtl/copy_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : copy_scheduler
// Brief   : Queues copy jobs and issues them one at a time to a copier via a
//           start/finished handshake, reporting each completion by tag.
//           Optional WAIT watchdog: define COPY_SCHED_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module copy_scheduler
    import copy_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = c_ADDR_W,
    parameter int TAG_W   = c_TAG_W,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input wire logic    CLK,
    input wire logic    RST,
    copy_sched_if.slave bus
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("copy_scheduler: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    sched_state_t           r_state;
    job_t                   w_push_job;
    job_t                   w_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic [ADDR_W-1:0]      r_cp_src;
    logic [ADDR_W-1:0]      r_cp_dst;
    logic [ADDR_W-1:0]      r_cp_size;
    logic [TAG_W-1:0]       r_tag;
    logic                   w_timeout;
    logic                   w_err_latched;

    // Acceptance looks only at registered occupancy, so a same-cycle pop
    // never frees room for a push.
    assign bus.req_ready = !w_full && (r_state != FAULT);
    assign w_push        = bus.req_valid && bus.req_ready;
    assign w_pop         = (r_state == IDLE) && !w_empty;
    assign w_push_job    = '{src: bus.req_src, dst: bus.req_dst,
                             size: bus.req_size, tag: bus.req_tag};

    copy_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wr_data (w_push_job),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

`ifdef COPY_SCHED_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == LAUNCH)    r_wait_cnt <= '0;
            else if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            if (w_timeout)            r_err      <= 1'b1;
        end
    end

    assign w_timeout     = (r_state == WAIT) && !bus.cp_finished &&
                           (r_wait_cnt == c_CNT_W'(TIMEOUT - 1));
    assign w_err_latched = r_err;
    assign bus.done_err  = (r_state == RETIRE) && r_err;
`else
    assign w_timeout     = 1'b0;
    assign w_err_latched = 1'b0;
    assign bus.done_err  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cp_src  <= '0;
            r_cp_dst  <= '0;
            r_cp_size <= '0;
            r_tag     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_tag <= w_head.tag;
                        // Zero-length jobs retire without ever touching the copier.
                        if (w_head.size != '0) begin
                            r_cp_src  <= w_head.src;
                            r_cp_dst  <= w_head.dst;
                            r_cp_size <= w_head.size;
                            r_state   <= LAUNCH;
                        end else begin
                            r_state   <= RETIRE;
                        end
                    end
                end
                LAUNCH:  r_state <= WAIT;
                WAIT:    if (bus.cp_finished || w_timeout) r_state <= RETIRE;
                RETIRE:  r_state <= w_err_latched ? FAULT : IDLE;
                FAULT:   r_state <= FAULT;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cp_start    = (r_state == LAUNCH);
    assign bus.cp_src      = r_cp_src;
    assign bus.cp_dst      = r_cp_dst;
    assign bus.cp_size     = r_cp_size;
    assign bus.done_valid  = (r_state == RETIRE);
    assign bus.done_tag    = r_tag;
    assign bus.busy        = (r_state != IDLE) || !w_empty;
    assign bus.queue_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_copy_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_copy_scheduler
// Brief   : Self-checking bench: directed and random jobs against a
//           latency-rule reference model with a randomized copier.
// Revision: 1.0
// ============================================================================
module tb_copy_scheduler;
    import copy_sched_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int TAG_W  = 2;
`ifdef COPY_SCHED_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 1024;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;

    copy_sched_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

    copy_scheduler #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int   total = 0;
    int   bad   = 0;

    // Reference model: FIFO contents plus edge timestamps derived from the
    // documented latencies (pop edge, start edge, finish edge, next pop edge).
    job_t m_q[$];
    job_t m_job;
    job_t m_cp;
    bit   m_active;
    bit   m_fault;
    bit   m_acc;
    int   m_edge;
    int   m_idle_edge;
    int   m_start_edge;
    int   m_finish_edge;
    int   delay_mode;     // >0 fixed copier delay, 0 random, <0 never finishes
    bit   stim_valid;
    job_t stim_job;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic job_t rand_job();
        job_t j;
        j.src  = 8'($urandom);
        j.dst  = 8'($urandom);
        j.size = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        j.tag  = 2'($urandom);
        return j;
    endfunction

    task automatic tick();
        bit               fin;
        bit               exp_start;
        bit               exp_done;
        bit               exp_err;
        logic [TAG_W-1:0] exp_tag;
        exp_start = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_tag   = '0;
        fin       = 1'b0;
        // Spurious finish pulses only where the scheduler must ignore them.
        if (m_active && (m_edge + 1) == m_finish_edge) fin = 1'b1;
        else if (!m_active || m_edge == m_start_edge) fin = ($urandom_range(0, 3) == 0);
        bus.cp_finished = fin;
        bus.req_valid   = stim_valid;
        bus.req_src     = stim_job.src;
        bus.req_dst     = stim_job.dst;
        bus.req_size    = stim_job.size;
        bus.req_tag     = stim_job.tag;
        m_acc = stim_valid && !m_fault && (m_q.size() < DEPTH);
        chk("req_ready", 32'(bus.req_ready), 32'(!m_fault && m_q.size() < DEPTH));
        @(posedge CLK);
        m_edge++;
        if (m_active && m_edge == m_finish_edge) begin
            exp_done    = 1'b1;
            exp_tag     = m_job.tag;
            m_active    = 1'b0;
            m_idle_edge = m_edge + 2;
        end
`ifdef COPY_SCHED_TIMEOUT_EN
        else if (m_active && m_edge == m_start_edge + TIMEOUT + 1) begin
            exp_done = 1'b1;
            exp_err  = 1'b1;
            exp_tag  = m_job.tag;
            m_active = 1'b0;
            m_fault  = 1'b1;
        end
`endif
        else if (!m_active && !m_fault && m_q.size() != 0 && m_edge >= m_idle_edge) begin
            m_job = m_q.pop_front();
            if (m_job.size != 0) begin
                exp_start    = 1'b1;
                m_active     = 1'b1;
                m_start_edge = m_edge;
                m_cp         = m_job;
                if (delay_mode > 0)      m_finish_edge = m_edge + delay_mode;
                else if (delay_mode < 0) m_finish_edge = -1;
                else                     m_finish_edge = m_edge + int'($urandom_range(2, 10));
            end else begin
                exp_done    = 1'b1;
                exp_tag     = m_job.tag;
                m_idle_edge = m_edge + 2;
            end
        end
        if (m_acc) m_q.push_back(stim_job);
        #1;
        chk("cp_start",    32'(bus.cp_start),    32'(exp_start));
        chk("done_valid",  32'(bus.done_valid),  32'(exp_done));
        chk("done_err",    32'(bus.done_err),    32'(exp_err));
        if (exp_done) chk("done_tag", 32'(bus.done_tag), 32'(exp_tag));
        chk("queue_count", 32'(bus.queue_count), 32'(m_q.size()));
        chk("busy",        32'(bus.busy),        32'(m_q.size() != 0 || m_active || exp_done || m_fault));
        chk("cp_src",      32'(bus.cp_src),      32'(m_cp.src));
        chk("cp_dst",      32'(bus.cp_dst),      32'(m_cp.dst));
        chk("cp_size",     32'(bus.cp_size),     32'(m_cp.size));
    endtask

    task automatic do_reset();
        RST             = 1'b1;
        stim_valid      = 1'b0;
        bus.req_valid   = 1'b0;
        bus.cp_finished = 1'b0;
        @(posedge CLK);
        m_edge++;
        m_q.delete();
        m_active    = 1'b0;
        m_fault     = 1'b0;
        m_cp        = '0;
        m_idle_edge = m_edge + 1;
        #1;
        RST = 1'b0;
        chk("rst_cp_start",   32'(bus.cp_start),    32'd0);
        chk("rst_done_valid", 32'(bus.done_valid),  32'd0);
        chk("rst_done_err",   32'(bus.done_err),    32'd0);
        chk("rst_done_tag",   32'(bus.done_tag),    32'd0);
        chk("rst_count",      32'(bus.queue_count), 32'd0);
        chk("rst_busy",       32'(bus.busy),        32'd0);
        chk("rst_ready",      32'(bus.req_ready),   32'd1);
        chk("rst_cp_regs",    {8'd0, bus.cp_src, bus.cp_dst, bus.cp_size}, 32'd0);
    endtask

    task automatic push_job(input job_t j);
        int n;
        n          = 0;
        stim_valid = 1'b1;
        stim_job   = j;
        m_acc      = 1'b0;
        while (!m_acc && n < 200) begin
            tick();
            n++;
        end
        stim_valid = 1'b0;
        chk("push_accept_bound", 32'(m_acc), 32'd1);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((m_active || m_q.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("drain_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        bus.req_valid   = 1'b0;
        bus.cp_finished = 1'b0;
        bus.req_src     = '0;
        bus.req_dst     = '0;
        bus.req_size    = '0;
        bus.req_tag     = '0;
        stim_valid      = 1'b0;
        stim_job        = '0;
        m_edge          = 0;
        m_start_edge    = -10;
        m_finish_edge   = -1;
        delay_mode      = 0;
        do_reset();

        // Single job, copier finishes 8 cycles after start.
        delay_mode = 8;
        push_job('{src: 8'h10, dst: 8'h80, size: 8'd4, tag: 2'd1});
        chk("lat_pre_start", 32'(bus.cp_start), 32'd0);
        tick();
        chk("lat_start", 32'(bus.cp_start), 32'd1);
        chk("lat_cp_regs", {8'd0, bus.cp_src, bus.cp_dst, bus.cp_size}, 32'h0010_8004);
        drain(100);

        // Back-to-back pushes against a slow copier until the FIFO fills.
        delay_mode = 20;
        for (int i = 0; i < 5; i++)
            push_job('{src: 8'(i * 16), dst: 8'(8'h80 + i), size: 8'(i + 1), tag: 2'(i)});
        chk("full_ready", 32'(bus.req_ready),   32'd0);
        chk("full_count", 32'(bus.queue_count), 32'd4);
        push_job('{src: 8'h55, dst: 8'hAA, size: 8'd9, tag: 2'd1});
        drain(400);

        // Zero-size job between two normal jobs.
        delay_mode = 0;
        push_job('{src: 8'h20, dst: 8'h90, size: 8'd5, tag: 2'd0});
        push_job('{src: 8'h30, dst: 8'hA0, size: 8'd0, tag: 2'd2});
        push_job('{src: 8'h40, dst: 8'hB0, size: 8'd6, tag: 2'd3});
        drain(200);

        // Random traffic with a random-latency copier.
        for (int i = 0; i < 400; i++) begin
            if (!stim_valid || m_acc) stim_job = rand_job();
            stim_valid = ($urandom_range(0, 1) == 1);
            tick();
        end
        stim_valid = 1'b0;
        drain(400);

        // Reset while waiting on the copier with two jobs queued.
        delay_mode = 50;
        push_job(rand_job() | job_t'({8'd0, 8'd0, 8'd1, 2'd0}));
        push_job(rand_job());
        push_job(rand_job());
        n = 0;
        while (!(m_active && m_edge > m_start_edge && m_q.size() == 2) && n < 100) begin
            tick();
            n++;
        end
        chk("pre_rst_count", 32'(bus.queue_count), 32'd2);
        do_reset();
        for (int i = 0; i < 20; i++) tick();

        // Copier that never finishes.
        delay_mode = -1;
        push_job('{src: 8'h01, dst: 8'h02, size: 8'd3, tag: 2'd2});
        for (int i = 0; i < 1000; i++) tick();
        chk("hang_busy",     32'(bus.busy),     32'd1);
        chk("hang_done_err", 32'(bus.done_err), 32'd0);
`ifdef COPY_SCHED_TIMEOUT_EN
        chk("fault_ready", 32'(bus.req_ready), 32'd0);
`else
        chk("hang_ready",  32'(bus.req_ready), 32'd1);
`endif
        do_reset();
        delay_mode = 0;
        push_job('{src: 8'h0A, dst: 8'h0B, size: 8'd2, tag: 2'd3});
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
